// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between IFU (read-only) and LSU (read/write).
// Latency: request accepted in cycle 0, memory strobe in cycle LATENCY, response from cycle LATENCY+1.
// Backpressure: one transaction in flight; requests are refused until the owner takes its response.
module pmem_arbiter #(
    parameter int LATENCY = 1,
    parameter int AW      = 64
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_req_pc,
    output logic          ifu_resp_valid,
    input  logic          ifu_resp_ready,
    output logic [31:0]   ifu_resp_inst,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_req_addr,
    input  logic          lsu_req_wen,
    input  logic [63:0]   lsu_req_wdata,
    input  logic [7:0]    lsu_req_wmask,
    output logic          lsu_resp_valid,
    input  logic          lsu_resp_ready,
    output logic [63:0]   lsu_resp_rdata,

    output logic          mem_valid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [63:0]   mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic [63:0]   mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic       OWN_IFU  = 1'b0;
    localparam logic       OWN_LSU  = 1'b1;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t        state;
    logic [7:0]    cnt;
    logic          last_grant;
    logic          owner;
    logic [AW-1:0] addr_q;
    logic          wen_q;
    logic [63:0]   wdata_q;
    logic [7:0]    wmask_q;
    logic          pc2_q;
    logic [63:0]   rdata_q;

    logic grant_ifu;
    logic grant_lsu;
    logic strobe;
    logic ifu_resp;
    logic lsu_resp;
    logic resp_fire;

    // The requester that did not win last time takes a tie.
    assign grant_ifu = ifu_req_valid & (~lsu_req_valid | (last_grant == OWN_LSU));
    assign grant_lsu = lsu_req_valid & (~ifu_req_valid | (last_grant == OWN_IFU));

    assign ifu_req_ready = (state == IDLE) & grant_ifu;
    assign lsu_req_ready = (state == IDLE) & grant_lsu;

    assign strobe    = (state == BUSY) && (cnt == 8'd0);
    assign ifu_resp  = (state == RESP) && (owner == OWN_IFU);
    assign lsu_resp  = (state == RESP) && (owner == OWN_LSU);
    assign resp_fire = (ifu_resp & ifu_resp_ready) | (lsu_resp & lsu_resp_ready);

    assign mem_valid = strobe;
    assign mem_addr  = strobe ? addr_q  : '0;
    assign mem_wen   = strobe & wen_q;
    assign mem_wdata = strobe ? wdata_q : '0;
    assign mem_wmask = strobe ? wmask_q : '0;

    assign ifu_resp_valid = ifu_resp;
    assign ifu_resp_inst  = !ifu_resp ? 32'h0 : (pc2_q ? rdata_q[63:32] : rdata_q[31:0]);
    assign lsu_resp_valid = lsu_resp;
    assign lsu_resp_rdata = lsu_resp ? rdata_q : 64'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= OWN_LSU;
            owner      <= OWN_IFU;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            pc2_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lsu_req_ready) begin
                        owner      <= OWN_LSU;
                        last_grant <= OWN_LSU;
                        addr_q     <= lsu_req_addr & ~AW'(7);
                        wen_q      <= lsu_req_wen;
                        wdata_q    <= lsu_req_wdata;
                        wmask_q    <= lsu_req_wmask;
                        pc2_q      <= 1'b0;
                        cnt        <= CNT_INIT;
                        state      <= BUSY;
                    end else if (ifu_req_ready) begin
                        owner      <= OWN_IFU;
                        last_grant <= OWN_IFU;
                        addr_q     <= ifu_req_pc & ~AW'(7);
                        wen_q      <= 1'b0;
                        wdata_q    <= '0;
                        wmask_q    <= '0;
                        pc2_q      <= ifu_req_pc[2];
                        cnt        <= CNT_INIT;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 8'd0) begin
                        rdata_q <= wen_q ? 64'h0 : mem_rdata;
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                RESP: begin
                    if (resp_fire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: three instances at LATENCY 1, 3 and 4, each with its own stimulus.
// Latency: a transaction-level model predicts every output each cycle from accept time and age.
// Backpressure: directed tests hold resp_ready low and raise competing requests during RESP.
module tb_pmem_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst            [3];
    logic        ifu_req_valid  [3];
    logic        ifu_req_ready  [3];
    logic [63:0] ifu_req_pc     [3];
    logic        ifu_resp_valid [3];
    logic        ifu_resp_ready [3];
    logic [31:0] ifu_resp_inst  [3];
    logic        lsu_req_valid  [3];
    logic        lsu_req_ready  [3];
    logic [63:0] lsu_req_addr   [3];
    logic        lsu_req_wen    [3];
    logic [63:0] lsu_req_wdata  [3];
    logic [7:0]  lsu_req_wmask  [3];
    logic        lsu_resp_valid [3];
    logic        lsu_resp_ready [3];
    logic [63:0] lsu_resp_rdata [3];
    logic        mem_valid      [3];
    logic [63:0] mem_addr       [3];
    logic        mem_wen        [3];
    logic [63:0] mem_wdata      [3];
    logic [7:0]  mem_wmask      [3];
    logic [63:0] mem_rdata      [3];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;

        pmem_arbiter #(.LATENCY(L), .AW(64)) dut (
            .clock          (clock),
            .reset          (rst[g]),
            .ifu_req_valid  (ifu_req_valid[g]),
            .ifu_req_ready  (ifu_req_ready[g]),
            .ifu_req_pc     (ifu_req_pc[g]),
            .ifu_resp_valid (ifu_resp_valid[g]),
            .ifu_resp_ready (ifu_resp_ready[g]),
            .ifu_resp_inst  (ifu_resp_inst[g]),
            .lsu_req_valid  (lsu_req_valid[g]),
            .lsu_req_ready  (lsu_req_ready[g]),
            .lsu_req_addr   (lsu_req_addr[g]),
            .lsu_req_wen    (lsu_req_wen[g]),
            .lsu_req_wdata  (lsu_req_wdata[g]),
            .lsu_req_wmask  (lsu_req_wmask[g]),
            .lsu_resp_valid (lsu_resp_valid[g]),
            .lsu_resp_ready (lsu_resp_ready[g]),
            .lsu_resp_rdata (lsu_resp_rdata[g]),
            .mem_valid      (mem_valid[g]),
            .mem_addr       (mem_addr[g]),
            .mem_wen        (mem_wen[g]),
            .mem_wdata      (mem_wdata[g]),
            .mem_wmask      (mem_wmask[g]),
            .mem_rdata      (mem_rdata[g])
        );

        // One in-flight transaction, described by who owns it and how many cycles ago it was accepted.
        bit          m_out   = 1'b0;
        bit          m_own   = 1'b0;
        bit          m_last  = 1'b1;
        bit          m_pc2   = 1'b0;
        bit          m_wen   = 1'b0;
        logic [63:0] m_addr  = '0;
        logic [63:0] m_wdata = '0;
        logic [63:0] m_rdata = '0;
        logic [7:0]  m_wmask = '0;
        int          m_age   = 0;

        always @(negedge clock) begin
            bit wi;
            bit wl;
            bit stb;
            bit rsp;
            bit ri;
            bit rl;
            logic [237:0] e;
            logic [237:0] a;
            wi = 1'b0;
            wl = 1'b0;
            if (!m_out) begin
                if (ifu_req_valid[g] && lsu_req_valid[g]) begin
                    wi = m_last;
                    wl = !m_last;
                end else begin
                    wi = ifu_req_valid[g];
                    wl = lsu_req_valid[g];
                end
            end
            stb = m_out && (m_age == L);
            rsp = m_out && (m_age > L);
            ri  = rsp && !m_own;
            rl  = rsp && m_own;
            e = {wi, wl, ri, ri ? (m_pc2 ? m_rdata[63:32] : m_rdata[31:0]) : 32'h0,
                 rl, rl ? m_rdata : 64'h0,
                 stb, stb ? m_addr : 64'h0, stb && m_wen, stb ? m_wdata : 64'h0, stb ? m_wmask : 8'h0};
            a = {ifu_req_ready[g], lsu_req_ready[g], ifu_resp_valid[g], ifu_resp_inst[g],
                 lsu_resp_valid[g], lsu_resp_rdata[g],
                 mem_valid[g], mem_addr[g], mem_wen[g], mem_wdata[g], mem_wmask[g]};
            if (chk_en) begin
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL lane%0d model_outputs: got %h expected %h", g, a, e);
                end
            end
            if (rst[g]) begin
                m_out  <= 1'b0;
                m_last <= 1'b1;
                m_age  <= 0;
            end else if (wi || wl) begin
                m_out   <= 1'b1;
                m_own   <= wl;
                m_last  <= wl;
                m_age   <= 1;
                m_addr  <= (wl ? lsu_req_addr[g] : ifu_req_pc[g]) & ~64'h7;
                m_pc2   <= wl ? 1'b0 : ifu_req_pc[g][2];
                m_wen   <= wl && lsu_req_wen[g];
                m_wdata <= wl ? lsu_req_wdata[g] : 64'h0;
                m_wmask <= wl ? lsu_req_wmask[g] : 8'h0;
            end else if (m_out) begin
                if (stb) m_rdata <= m_wen ? 64'h0 : mem_rdata[g];
                if (rsp && (m_own ? lsu_resp_ready[g] : ifu_resp_ready[g])) m_out <= 1'b0;
                else if (m_age <= L) m_age <= m_age + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        int gwho[$];
        int gcyc[$];
        int nstb;
        int ni;
        int nl;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            ifu_req_valid[i] = 1'b0;  ifu_req_pc[i] = '0;  ifu_resp_ready[i] = 1'b0;
            lsu_req_valid[i] = 1'b0;  lsu_req_addr[i] = '0; lsu_req_wen[i] = 1'b0;
            lsu_req_wdata[i] = '0;    lsu_req_wmask[i] = '0; lsu_resp_ready[i] = 1'b0;
            mem_rdata[i] = '0;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_mem_valid", mem_valid[0], 0);
        chk("rst_ifu_resp_valid", ifu_resp_valid[1], 0);
        chk("rst_lsu_resp_rdata", lsu_resp_rdata[2], 0);

        // LATENCY=1 fetch from the upper word.
        tick();
        ifu_req_valid[0] = 1'b1; ifu_req_pc[0] = 64'h80000004;
        mem_rdata[0] = 64'h00100073_00000413;
        #1; chk("t1_ready", ifu_req_ready[0], 1);
        tick(); ifu_req_valid[0] = 1'b0;
        #1; chk("t1_mem_valid", mem_valid[0], 1);
        chk("t1_mem_addr", mem_addr[0], 64'h80000000);
        tick();
        #1; chk("t1_resp_valid", ifu_resp_valid[0], 1);
        chk("t1_inst", ifu_resp_inst[0], 32'h00100073);
        ifu_resp_ready[0] = 1'b1;
        tick();
        #1; chk("t1_resp_done", ifu_resp_valid[0], 0);
        ifu_resp_ready[0] = 1'b0;

        // Both requesters held valid on the LATENCY=3 lane.
        tick();
        ifu_req_valid[1] = 1'b1; ifu_req_pc[1] = 64'h80000100;
        lsu_req_valid[1] = 1'b1; lsu_req_addr[1] = 64'h80000208;
        ifu_resp_ready[1] = 1'b1; lsu_resp_ready[1] = 1'b1;
        mem_rdata[1] = 64'h0123456789ABCDEF;
        nstb = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (ifu_req_ready[1]) begin gwho.push_back(0); gcyc.push_back(c); end
            if (lsu_req_ready[1]) begin gwho.push_back(1); gcyc.push_back(c); end
            if (mem_valid[1]) nstb++;
            tick();
        end
        ifu_req_valid[1] = 1'b0; lsu_req_valid[1] = 1'b0;
        chk("t2_ngrants", gwho.size(), 4);
        chk("t2_strobes", nstb, 4);
        for (int k = 0; k < 4 && k < gwho.size(); k++) begin
            chk("t2_who", gwho[k], k % 2);
            chk("t2_cycle", gcyc[k], 5 * k);
        end

        // LSU write with unaligned address, LATENCY=3.
        tick();
        lsu_req_valid[1] = 1'b1; lsu_req_addr[1] = 64'h80001003; lsu_req_wen[1] = 1'b1;
        lsu_req_wdata[1] = 64'h1122334455667788; lsu_req_wmask[1] = 8'hF0;
        lsu_resp_ready[1] = 1'b0; mem_rdata[1] = 64'hFFFFFFFFFFFFFFFF;
        #1; chk("t3_ready", lsu_req_ready[1], 1);
        tick(); lsu_req_valid[1] = 1'b0;
        #1; chk("t3_c1_mem_valid", mem_valid[1], 0);
        tick();
        #1; chk("t3_c2_mem_valid", mem_valid[1], 0);
        tick();
        #1; chk("t3_mem_valid", mem_valid[1], 1);
        chk("t3_mem_addr", mem_addr[1], 64'h80001000);
        chk("t3_mem_wen", mem_wen[1], 1);
        chk("t3_mem_wmask", mem_wmask[1], 8'hF0);
        chk("t3_mem_wdata", mem_wdata[1], 64'h1122334455667788);
        tick();
        #1; chk("t3_resp_valid", lsu_resp_valid[1], 1);
        chk("t3_resp_rdata", lsu_resp_rdata[1], 0);
        lsu_resp_ready[1] = 1'b1;
        tick();
        #1; chk("t3_resp_done", lsu_resp_valid[1], 0);
        lsu_resp_ready[1] = 1'b0;

        // LSU read response held under backpressure while both sides request.
        tick();
        lsu_req_valid[1] = 1'b1; lsu_req_addr[1] = 64'h80002008; lsu_req_wen[1] = 1'b0;
        lsu_req_wmask[1] = 8'hFF; mem_rdata[1] = 64'hCAFEF00D12345678;
        #1; chk("t4_ready", lsu_req_ready[1], 1);
        tick(); lsu_req_valid[1] = 1'b0;
        tick();
        tick();
        tick();
        mem_rdata[1] = 64'h0; ifu_req_valid[1] = 1'b1; lsu_req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t4_hold_valid", lsu_resp_valid[1], 1);
            chk("t4_hold_rdata", lsu_resp_rdata[1], 64'hCAFEF00D12345678);
            chk("t4_no_ifu_ready", ifu_req_ready[1], 0);
            chk("t4_no_lsu_ready", lsu_req_ready[1], 0);
            tick();
        end
        lsu_resp_ready[1] = 1'b1; lsu_req_valid[1] = 1'b0;
        #1; chk("t4_fire_valid", lsu_resp_valid[1], 1);
        chk("t4_fire_no_ready", ifu_req_ready[1], 0);
        tick();
        #1; chk("t4_idle_resp", lsu_resp_valid[1], 0);
        chk("t4_idle_ready", ifu_req_ready[1], 1);
        tick();
        ifu_req_valid[1] = 1'b0; lsu_resp_ready[1] = 1'b0;
        repeat (6) tick();

        // Reset lands in the first BUSY cycle of a LATENCY=4 fetch.
        ifu_req_valid[2] = 1'b1; ifu_req_pc[2] = 64'h80000010;
        ifu_resp_ready[2] = 1'b1; lsu_resp_ready[2] = 1'b1; mem_rdata[2] = 64'h1234;
        #1; chk("t5_ready", ifu_req_ready[2], 1);
        tick(); ifu_req_valid[2] = 1'b0; rst[2] = 1'b1;
        tick(); rst[2] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t5_mem_valid", mem_valid[2], 0);
            chk("t5_mem_addr", mem_addr[2], 0);
            chk("t5_ifu_resp_valid", ifu_resp_valid[2], 0);
            chk("t5_ifu_resp_inst", ifu_resp_inst[2], 0);
            chk("t5_lsu_resp_valid", lsu_resp_valid[2], 0);
            tick();
        end
        ifu_req_valid[2] = 1'b1; lsu_req_valid[2] = 1'b1; lsu_req_addr[2] = 64'h80004000;
        #1; chk("t5_tie_ifu", ifu_req_ready[2], 1);
        chk("t5_tie_lsu", lsu_req_ready[2], 0);
        tick(); ifu_req_valid[2] = 1'b0; lsu_req_valid[2] = 1'b0;
        repeat (7) tick();

        // IFU gives up while the LSU takes the port, then round-robin resumes.
        ifu_req_valid[0] = 1'b1; ifu_req_pc[0] = 64'h80000020;
        lsu_req_valid[0] = 1'b1; lsu_req_addr[0] = 64'h80003000; lsu_req_wen[0] = 1'b0;
        ifu_resp_ready[0] = 1'b1; lsu_resp_ready[0] = 1'b1; mem_rdata[0] = 64'h55;
        #1; chk("t6_lsu_ready", lsu_req_ready[0], 1);
        chk("t6_ifu_ready", ifu_req_ready[0], 0);
        tick(); ifu_req_valid[0] = 1'b0; lsu_req_valid[0] = 1'b0;
        nstb = 0; ni = 0; nl = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (mem_valid[0]) nstb++;
            if (ifu_resp_valid[0]) ni++;
            if (lsu_resp_valid[0]) nl++;
            tick();
        end
        chk("t6_strobes", nstb, 1);
        chk("t6_ifu_resps", ni, 0);
        chk("t6_lsu_resps", nl, 1);
        ifu_req_valid[0] = 1'b1; lsu_req_valid[0] = 1'b1;
        #1; chk("t6_next_ifu", ifu_req_ready[0], 1);
        chk("t6_next_lsu", lsu_req_ready[0], 0);
        tick(); ifu_req_valid[0] = 1'b0; lsu_req_valid[0] = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single DPI-C physical-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Arbitrates round-robin and holds one outstanding transaction at a time.
- Models a programmable memory latency with a down-counter.
- Issues exactly one single-cycle strobe to the memory port per accepted request, registers the 64-bit read data, and returns a response to the owner over a valid/ready handshake.

Parameters:
- LATENCY, 1, number of BUSY cycles between request acceptance and the memory strobe cycle; legal range 1..255.
- AW, 64, address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_pc  in  AW  fetch address
- ifu_resp_valid  out  1  IFU response valid
- ifu_resp_ready  in  1  IFU takes response
- ifu_resp_inst  out  32  fetched instruction
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_addr  in  AW  data address
- lsu_req_wen  in  1  1 = write, 0 = read
- lsu_req_wdata  in  64  write data
- lsu_req_wmask  in  8  byte write mask
- lsu_resp_valid  out  1  LSU response valid
- lsu_resp_ready  in  1  LSU takes response
- lsu_resp_rdata  out  64  read data
- mem_valid  out  1  one-cycle strobe to the DPI memory wrapper
- mem_addr  out  AW  8-byte-aligned address
- mem_wen  out  1  write strobe qualifier
- mem_wdata  out  64  write data
- mem_wmask  out  8  write byte mask
- mem_rdata  in  64  combinational read data, valid in the same cycle as mem_valid

Behaviour:
- The clock is `clock`; reset is synchronous and active-high on `reset`.
- Reset values:
  - State is IDLE.
  - All valid/ready/strobe outputs are 0; all data outputs are 0.
  - last_grant = LSU, so the IFU wins the first tie.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready is combinational: asserted only to the winning requester, only in IDLE, and only while its valid is high.
  - Single requester valid: that requester wins.
  - Both valid: the requester other than last_grant wins (round-robin).
  - On handshake (valid & ready), the block latches owner, address, wen, wdata and wmask.
  - Latched address is forced to 8-byte alignment: addr & ~7.
  - Latched wmask is forced to 0 for IFU requests.
  - The block loads cnt = LATENCY-1, updates last_grant, and moves to BUSY.
- BUSY:
  - cnt decrements each cycle while cnt != 0.
  - On the cycle cnt == 0, mem_valid = 1 and mem_addr/wen/wdata/wmask are driven from the latches.
  - Read data is registered as rdata_q = mem_wen ? 0 : mem_rdata, and the state moves to RESP.
  - mem_valid is high for exactly one cycle per transaction.
  - mem_addr/wen/wdata/wmask are 0 whenever mem_valid = 0.
- RESP:
  - The owner's resp_valid = 1; the other requester's resp_valid = 0.
  - resp_valid and the response data are held stable until the owner's resp_ready is high. On that cycle the state moves to IDLE.
  - A new request is not accepted in the same cycle as the response handshake.
- Response data:
  - ifu_resp_inst = pc_q[2] ? rdata_q[63:32] : rdata_q[31:0].
  - lsu_resp_rdata = rdata_q; it is 0 for writes.
  - Response data outputs are 0 when the corresponding resp_valid is 0.
- Timing: handshake in cycle 0, BUSY in cycles 1..LATENCY, mem_valid in cycle LATENCY, resp_valid from cycle LATENCY+1. Back-to-back throughput is one transaction per LATENCY+2 cycles, assuming resp_ready is already high.
- A requester deasserting valid before its handshake is legal. Request fields are sampled only at the handshake.
- Reset mid-transaction:
  - The transaction is dropped and the state returns to IDLE.
  - No further mem_valid is issued for the dropped transaction and no response is returned.
  - If reset lands on the mem_valid cycle, that write has already reached memory; no retry is made.

Test Plan:
- LATENCY=1, IFU req pc=0x80000004 alone. Required: ready in cycle 0, mem_valid with mem_addr=0x80000000 in cycle 1, given mem_rdata=0x00100073_00000413 → ifu_resp_inst=0x00100073 from cycle 2.
- Both requesters valid continuously, 4 transactions. Required: grants IFU, LSU, IFU, LSU; exactly one mem_valid per grant; never two outstanding.
- LSU write addr=0x80001003, wdata=0x1122334455667788, wmask=0xF0, LATENCY=3. Required: mem_valid in cycle 3 with addr=0x80001000, wen=1, mask=0xF0; lsu_resp_valid in cycle 4 with rdata=0.
- RESP back-pressure: lsu_resp_ready held low for 5 cycles. Required: resp_valid and rdata stay stable, no new ready to either side, and the state returns to IDLE the cycle after resp_ready rises.
- Reset asserted in cycle 1 of a LATENCY=4 read. Required: no mem_valid, no resp_valid, all outputs 0, and the next simultaneous request grants IFU.
- IFU valid dropped before ready, i.e. the LSU owns the port. Required: no IFU transaction is issued and the next grant follows last_grant correctly.
